mssd_frame_tx: RTL and testbench
================================

// Module: mssd_frame_tx
// PURPOSE
//  Upstream framer for the MSSD serial demultiplexer. Accepts one parallel
//  request (port, length, payload) over a valid/ready handshake.
//  Serializes it onto serOut in the frame format MSSD decodes on serIn.
//  serOut wires directly to MSSD.serIn; both blocks share clk and rst.
//  Frame format: start bit 0, port[1:0] MSB first, len[3:0] MSB first,
//  payload bits data[0]..data[len] (LSB first), then idle-high gap.
// PARAMETERS
//  LENW  4  length-field width; payload width DW = 2**LENW (16); must match MSSD
//  GAP   1  minimum idle-high bits after each frame; legal range 1..15
// PORTS
//  clk        in   1     rising-edge clock, shared with MSSD
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     request valid
//  in_ready   out  1     block can accept; high only in IDLE
//  in_port    in   2     destination MSSD port (0..3)
//  in_len     in   LENW  payload length minus one (0 -> 1 bit, 15 -> 16 bits)
//  in_data    in   DW    payload; only bits [in_len:0] are sent
//  serOut     out  1     serial frame stream; idles at 1
//  busy       out  1     high while a frame or its gap is in progress
//  frame_done out  1     one-cycle pulse during the last payload bit
// BEHAVIOUR
//  Reset: state=IDLE, serOut=1, in_ready=1, busy=0, frame_done=0, regs cleared.
//  All outputs are registered, except in_ready, which is defined as (state==IDLE).
//  Handshake: accept on the edge where in_valid && in_ready. Capture port,
//   len and data into internal registers. Inputs are otherwise ignored; they
//   may change freely while busy.
//  FSM: IDLE -> START -> PORT(2) -> LEN(LENW) -> DATA(len+1) -> GAP(GAP) -> IDLE.
//   A single down-counter sequences the PORT/LEN/DATA/GAP bits. It is loaded on
//   entry to each state and the state is left when the count reaches 0.
//  Latency: the start bit appears on serOut in the cycle after the accept edge.
//  Frame length = 1+2+LENW+(len+1) bits (LENW=4: len+8 cycles), followed by
//   GAP cycles of serOut=1.
//  Shift rules: the port shifts out MSB first; len shifts out MSB first. The
//   payload register shifts right; serOut = data_reg[0] during DATA.
//  frame_done=1 only during the DATA cycle that carries data[len].
//  busy=1 from START through the final GAP cycle.
//  Back-to-back: with in_valid held high, the next accept happens in the IDLE
//   cycle that follows GAP. Consecutive frames are therefore separated by
//   exactly GAP+1 idle-high bits.
//  len=0: DATA lasts one cycle, and frame_done coincides with the first data bit.
//  Reset mid-frame: on the next edge, serOut=1 and state=IDLE, and the partial
//   frame is abandoned. MSSD is reset by the same rst, so no resync is needed.
//  in_port and in_len are full-range; no request is illegal. Bits of in_data
//   above len are never sent.
// TESTING
//  1 port=2'b10, len=3, data=16'h000B, accepted at cycle 0 -> serOut cycles 1..11
//    = 0,1,0,0,0,1,1,1,1,0,1; frame_done=1 at cycle 11 only; serOut=1 at
//    cycle 12; in_ready=1 again at cycle 13 (GAP=1).
//  2 port=3, len=15, data=16'hA5C3 -> 23-bit frame, payload bits 1,1,0,0,0,0,1,1,
//    1,0,1,0,0,1,0,1; frame_done at the 23rd bit; busy low after GAP.
//  3 Two requests with in_valid held high (port 0 len 0 data 1; then port 1 len 1
//    data 2'b10) -> frames 0,0,0,0,0,0,0,1 and 0,0,1,0,0,0,1,0,1, separated by
//    exactly 2 idle-high bits.
//  4 Assert rst during the LEN bits of a frame -> the next cycle shows serOut=1,
//    busy=0, in_ready=1; a new request then produces a correct frame.
//  5 Toggle in_port/in_len/in_data every cycle while busy -> the serialized frame
//    matches the values captured at accept; no extra accepts occur.
//  6 Loopback into MSSD for all 4 ports x len {0,7,15} with random data ->
//    MSSD outValid asserts and p[port] reproduces the payload bit-for-bit; other
//    p lines stay idle; error stays 0.

Source files
------------

// File: rtl/mssd_frame_tx.sv
// Serial framer feeding the MSSD demultiplexer: start bit, port, length and an
// LSB-first payload, followed by an idle-high gap of GAP bits.
module mssd_frame_tx #(
  parameter int LENW = 4,
  parameter int GAP  = 1,
  localparam int DW  = 2**LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_port,
  input  logic [LENW-1:0] in_len,
  input  logic [DW-1:0]   in_data,
  output logic            serOut,
  output logic            busy,
  output logic            frame_done
);

  localparam int HW = 2 + LENW;
  localparam int CW = (LENW > 4) ? LENW : 4;

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAPS} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [HW-1:0]   hdr_r, hdr_s;
  logic [LENW-1:0] len_r, len_s;
  logic [DW-1:0]   data_r, data_s;
  logic            ser_s, busy_s, done_s;

  assign in_ready = (state_r == IDLE);

  // Next state plus next-cycle serial bit; the outputs are registered, so each
  // branch computes the bit that the following state presents on the line.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hdr_s   = hdr_r;
    len_s   = len_r;
    data_s  = data_r;
    ser_s   = 1'b1;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = START;
          hdr_s   = {in_port, in_len};
          len_s   = in_len;
          data_s  = in_data;
          ser_s   = 1'b0;
        end else begin
          busy_s  = 1'b0;
        end
      end
      START: begin
        state_s = PORT;
        cnt_s   = CW'(1);
        ser_s   = hdr_r[HW-1];
      end
      PORT: begin
        hdr_s = {hdr_r[HW-2:0], 1'b0};
        ser_s = hdr_r[HW-2];
        if (cnt_r == CW'(0)) begin
          state_s = LEN;
          cnt_s   = CW'(LENW - 1);
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      LEN: begin
        if (cnt_r == CW'(0)) begin
          state_s = DATA;
          cnt_s   = CW'(len_r);
          ser_s   = data_r[0];
          done_s  = (len_r == {LENW{1'b0}});
        end else begin
          hdr_s   = {hdr_r[HW-2:0], 1'b0};
          ser_s   = hdr_r[HW-2];
          cnt_s   = cnt_r - CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == CW'(0)) begin
          state_s = GAPS;
          cnt_s   = CW'(GAP - 1);
        end else begin
          data_s  = {1'b0, data_r[DW-1:1]};
          ser_s   = data_r[1];
          done_s  = (cnt_r == CW'(1));
          cnt_s   = cnt_r - CW'(1);
        end
      end
      GAPS: begin
        if (cnt_r == CW'(0)) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      hdr_r      <= {HW{1'b0}};
      len_r      <= {LENW{1'b0}};
      data_r     <= {DW{1'b0}};
      serOut     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      hdr_r      <= hdr_s;
      len_r      <= len_s;
      data_r     <= data_s;
      serOut     <= ser_s;
      busy       <= busy_s;
      frame_done <= done_s;
    end
  end

endmodule

// File: tb/tb_mssd_frame_tx.sv
// Bench for mssd_frame_tx: a frame-level queue model checked every cycle, plus
// literal frame checks and a serial decoder standing in for the MSSD receiver.
module tb_mssd_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_port = 2'd0;
  logic [3:0]  in_len = 4'd0;
  logic [15:0] in_data = 16'd0;
  logic        serOut, busy, frame_done;

  mssd_frame_tx #(.LENW(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_port(in_port), .in_len(in_len), .in_data(in_data),
    .serOut(serOut), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit q_ser[$];
  bit q_done[$];
  bit q_busy[$];
  logic log_ser[0:4095];
  logic log_done[0:4095];
  logic log_busy[0:4095];
  logic log_rdy[0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Whole frame as the line must carry it, with GAP=1 trailing idle bit
  task automatic push_frame(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
    q_ser.push_back(1'b0); q_done.push_back(1'b0); q_busy.push_back(1'b1);
    for (int i = 1; i >= 0; i--) begin
      q_ser.push_back(p[i]); q_done.push_back(1'b0); q_busy.push_back(1'b1);
    end
    for (int i = 3; i >= 0; i--) begin
      q_ser.push_back(l[i]); q_done.push_back(1'b0); q_busy.push_back(1'b1);
    end
    for (int i = 0; i <= int'(l); i++) begin
      q_ser.push_back(d[i]); q_done.push_back(i == int'(l)); q_busy.push_back(1'b1);
    end
    q_ser.push_back(1'b1); q_done.push_back(1'b0); q_busy.push_back(1'b1);
  endtask

  // Per-cycle compare against the model, then model update for this edge
  always @(negedge clk) begin
    bit mready, es, ed, eb;
    if (cyc < 4096) begin
      log_ser[cyc] = serOut; log_done[cyc] = frame_done;
      log_busy[cyc] = busy; log_rdy[cyc] = in_ready;
    end
    if (chk_en) begin
      mready = (q_ser.size() == 0);
      if (mready) begin
        es = 1'b1; ed = 1'b0; eb = 1'b0;
      end else begin
        es = q_ser.pop_front(); ed = q_done.pop_front(); eb = q_busy.pop_front();
      end
      chk("serOut", 32'(serOut), 32'(es));
      chk("frame_done", 32'(frame_done), 32'(ed));
      chk("busy", 32'(busy), 32'(eb));
      chk("in_ready", 32'(in_ready), 32'(mready));
      if (rst) begin
        q_ser.delete(); q_done.delete(); q_busy.delete();
      end else if (in_valid && mready) begin
        push_frame(in_port, in_len, in_data);
      end
    end
  end

  task automatic send(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d, output int acc);
    in_port = p; in_len = l; in_data = d; in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL send_timeout got=no_accept want=accept");
      acc = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stand-in for the MSSD receiver: decode a frame from the logged line
  task automatic decode(input int a, input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
    logic [1:0] rp;
    logic [3:0] rl;
    logic [15:0] rd;
    rd = 16'd0;
    chk("dec_start", 32'(log_ser[a+1]), 32'd0);
    rp = {log_ser[a+2], log_ser[a+3]};
    rl = {log_ser[a+4], log_ser[a+5], log_ser[a+6], log_ser[a+7]};
    chk("dec_port", 32'(rp), 32'(p));
    chk("dec_len", 32'(rl), 32'(l));
    for (int i = 0; i <= int'(l); i++) rd[i] = log_ser[a+8+i];
    chk("dec_data", 32'(rd), 32'(d & ((32'd2 << l) - 32'd1)));
    chk("dec_gap", 32'(log_ser[a+9+int'(l)]), 32'd1);
  endtask

  initial begin
    int a, a2;
    logic [0:10] e1;
    logic [0:6]  h2;
    logic [0:15] p2;
    logic [0:7]  f3a;
    logic [0:8]  f3b;
    logic [15:0] rdat;
    logic [3:0]  lens [3];

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(2);

    // 1: port 2, len 3, data 0x000B
    e1 = 11'b01000111101;
    send(2'b10, 4'd3, 16'h000B, a);
    in_valid = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 11; i++) chk("t1_ser", 32'(log_ser[a+1+i]), 32'(e1[i]));
    for (int i = 1; i <= 12; i++) chk("t1_done", 32'(log_done[a+i]), 32'(i == 11));
    chk("t1_gap", 32'(log_ser[a+12]), 32'd1);
    chk("t1_rdy12", 32'(log_rdy[a+12]), 32'd0);
    chk("t1_rdy13", 32'(log_rdy[a+13]), 32'd1);

    // 2: port 3, len 15, data 0xA5C3
    h2 = 7'b0111111;
    p2 = 16'b1100001110100101;
    send(2'd3, 4'd15, 16'hA5C3, a);
    in_valid = 1'b0;
    wait_cyc(30);
    for (int i = 0; i < 7; i++) chk("t2_hdr", 32'(log_ser[a+1+i]), 32'(h2[i]));
    for (int i = 0; i < 16; i++) chk("t2_pay", 32'(log_ser[a+8+i]), 32'(p2[i]));
    chk("t2_done22", 32'(log_done[a+22]), 32'd0);
    chk("t2_done23", 32'(log_done[a+23]), 32'd1);
    chk("t2_busy24", 32'(log_busy[a+24]), 32'd1);
    chk("t2_busy25", 32'(log_busy[a+25]), 32'd0);

    // 3: back-to-back with in_valid held high
    f3a = 8'b00000001;
    f3b = 9'b001000101;
    send(2'd0, 4'd0, 16'h0001, a);
    send(2'd1, 4'd1, 16'h0002, a2);
    in_valid = 1'b0;
    wait_cyc(14);
    chk("t3_spacing", 32'(a2 - a), 32'd10);
    for (int i = 0; i < 8; i++) chk("t3_f1", 32'(log_ser[a+1+i]), 32'(f3a[i]));
    chk("t3_done_len0", 32'(log_done[a+8]), 32'd1);
    chk("t3_idle1", 32'(log_ser[a2-1]), 32'd1);
    chk("t3_idle2", 32'(log_ser[a2]), 32'd1);
    for (int i = 0; i < 9; i++) chk("t3_f2", 32'(log_ser[a2+1+i]), 32'(f3b[i]));

    // 4: reset during the LEN bits
    send(2'd2, 4'd9, 16'h1234, a);
    in_valid = 1'b0;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    chk("t4_ser", 32'(log_ser[a+6]), 32'd1);
    chk("t4_busy", 32'(log_busy[a+6]), 32'd0);
    chk("t4_rdy", 32'(log_rdy[a+6]), 32'd1);
    send(2'd1, 4'd5, 16'h002D, a);
    in_valid = 1'b0;
    wait_cyc(16);
    decode(a, 2'd1, 4'd5, 16'h002D);

    // 5: inputs churn while busy; in_valid dropped before the gap ends
    send(2'd3, 4'd6, 16'h0055, a);
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'($urandom); in_port = 2'($urandom);
      in_len = 4'($urandom); in_data = 16'($urandom);
      wait_cyc(1);
    end
    in_valid = 1'b0;
    wait_cyc(8);
    decode(a, 2'd3, 4'd6, 16'h0055);
    chk("t5_no_extra", 32'(log_busy[a+16]), 32'd0);

    // 6: all ports x len {0,7,15} with random data
    lens[0] = 4'd0; lens[1] = 4'd7; lens[2] = 4'd15;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        rdat = 16'($urandom);
        send(2'(p), lens[k], rdat, a);
        in_valid = 1'b0;
        wait_cyc(int'(lens[k]) + 12);
        decode(a, 2'(p), lens[k], rdat);
      end
    end

    wait_cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
